// File: rtl/led_scan_capture_if.sv
// Signal bundle between the LED row-scan monitor and its observer: scan inputs, read port and status.
interface led_scan_capture_if;
  logic [15:0] scan_row;
  logic [15:0] scan_col;
  logic [3:0]  rd_row;
  logic [15:0] rd_data;
  logic        frame_done;
  logic        locked;
  logic        err_onehot;
  logic        err_seq;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  modport master (
    output scan_row, scan_col, rd_row,
    input  rd_data, frame_done, locked, err_onehot, err_seq, frame_cnt, err_cnt
  );

  modport slave (
    input  scan_row, scan_col, rd_row,
    output rd_data, frame_done, locked, err_onehot, err_seq, frame_cnt, err_cnt
  );
endinterface

// File: rtl/led_scan_capture.sv
// Rebuilds the 16x16 LED frame from the one-hot row scan into a double-buffered store.
// Optional frame/error statistics counters are enabled by defining LED_CAPTURE_STATS_EN.
//
// state   | meaning
// HUNT    | not locked; waiting for a row-0 event to start a frame
// CAPTURE | locked; expecting row exp_idx next, commits on row 15
module led_scan_capture (
  input  logic             clk,
  input  logic             rst,
  led_scan_capture_if.slave bus
);

  typedef enum logic {HUNT, CAPTURE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  exp_idx, exp_nxt;
  logic [15:0] s_row, s_col, p_row;
  logic [15:0] shadow  [16];
  logic [15:0] display [16];
  logic [15:0] rd_data_q;
  logic        frame_done_q, err_onehot_q, err_seq_q;

  logic        row_event, row_onehot;
  logic [3:0]  row_idx;
  logic        shd_we, commit, seq_err, oh_err;

  assign row_event  = (s_row != p_row);
  assign row_onehot = (s_row != 16'd0) && ((s_row & (s_row - 16'd1)) == 16'd0);

  always_comb begin
    row_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (s_row[i]) row_idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_row <= '0;
      s_col <= '0;
      p_row <= '0;
    end else begin
      s_row <= bus.scan_row;
      s_col <= bus.scan_col;
      p_row <= s_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HUNT;
      exp_idx <= '0;
    end else begin
      state   <= state_nxt;
      exp_idx <= exp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_idx;
    shd_we    = 1'b0;
    commit    = 1'b0;
    seq_err   = 1'b0;
    oh_err    = 1'b0;
    if (row_event) begin
      case (state)
        HUNT: begin
          // Row 0 is the only entry point; zero is the idle value and never an error.
          if (row_onehot && row_idx == 4'd0) begin
            shd_we    = 1'b1;
            exp_nxt   = 4'd1;
            state_nxt = CAPTURE;
          end else if (s_row != 16'd0 && !row_onehot) begin
            oh_err = 1'b1;
          end
        end
        CAPTURE: begin
          if (!row_onehot) begin
            oh_err    = 1'b1;
            state_nxt = HUNT;
          end else if (row_idx == exp_idx) begin
            shd_we  = 1'b1;
            exp_nxt = exp_idx + 4'd1;
            commit  = (row_idx == 4'd15);
          end else if (row_idx == 4'd0) begin
            seq_err = 1'b1;
            shd_we  = 1'b1;
            exp_nxt = 4'd1;
          end else begin
            seq_err   = 1'b1;
            state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Row 15 goes straight from s_col into the display so the commit lands in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        shadow[i]  <= '0;
        display[i] <= '0;
      end
    end else begin
      if (shd_we) shadow[row_idx] <= s_col;
      if (commit) begin
        for (int i = 0; i < 15; i++) display[i] <= shadow[i];
        display[15] <= s_col;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
    end else begin
      rd_data_q    <= display[bus.rd_row];
      frame_done_q <= commit;
      err_onehot_q <= oh_err;
      err_seq_q    <= seq_err;
    end
  end

`ifdef LED_CAPTURE_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (commit) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((seq_err || oh_err) && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
`else
  assign bus.frame_cnt = 16'd0;
  assign bus.err_cnt   = 8'd0;
`endif

  assign bus.rd_data    = rd_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err_onehot = err_onehot_q;
  assign bus.err_seq    = err_seq_q;
  assign bus.locked     = (state == CAPTURE);

endmodule

// File: tb/tb_led_scan_capture.sv
// Bench for led_scan_capture: directed vector table, hand sequences and randomized scans
// compared every cycle against a frame-level reference model.
module tb_led_scan_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_scan_capture_if bus();

  led_scan_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int fd_seen = 0;
  int es_seen = 0;
  int eo_seen = 0;

  // Reference model: what the matrix shows, in frame/row terms.
  logic [15:0] m_disp   [16];
  logic [15:0] m_shadow [16];
  logic [15:0] m_s_row, m_p_row, m_s_col;
  bit          m_locked;
  int          m_next;
  logic [15:0] m_frames;
  int          m_errs;
  bit          m_fd, m_es, m_eo;
  logic [15:0] m_rd;

  typedef struct {
    logic [15:0] row;
    logic [15:0] col;
    logic [3:0]  rd_row;
    bit          fd;
    bit          lk;
    bit          es;
    bit          eo;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl[31];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_disp[i]   = '0;
      m_shadow[i] = '0;
    end
    m_s_row = '0; m_p_row = '0; m_s_col = '0;
    m_locked = 0; m_next = 0; m_frames = '0; m_errs = 0;
    m_fd = 0; m_es = 0; m_eo = 0; m_rd = '0;
  endtask

  task automatic model_edge(input logic [15:0] row, input logic [15:0] col, input logic [3:0] rr);
    int idx;
    bit oh;
    m_rd = m_disp[rr];
    m_fd = 0; m_es = 0; m_eo = 0;
    if (m_s_row != m_p_row) begin
      oh  = ($countones(m_s_row) == 1);
      idx = -1;
      for (int i = 0; i < 16; i++) if (m_s_row == (16'h1 << i)) idx = i;
      if (!m_locked) begin
        if (idx == 0) begin
          m_shadow[0] = m_s_col; m_next = 1; m_locked = 1;
        end else if (m_s_row != 0 && !oh) begin
          m_eo = 1;
        end
      end else begin
        if (!oh) begin
          m_eo = 1; m_locked = 0;
        end else if (idx == m_next) begin
          m_shadow[idx] = m_s_col;
          m_next = (m_next + 1) % 16;
          if (idx == 15) begin
            for (int i = 0; i < 16; i++) m_disp[i] = m_shadow[i];
            m_fd = 1;
          end
        end else if (idx == 0) begin
          m_es = 1; m_shadow[0] = m_s_col; m_next = 1;
        end else begin
          m_es = 1; m_locked = 0;
        end
      end
      if (m_fd) m_frames = m_frames + 16'd1;
      if ((m_es || m_eo) && m_errs < 255) m_errs++;
    end
    m_p_row = m_s_row;
    m_s_row = row;
    m_s_col = col;
  endtask

  task automatic cycle(input logic [15:0] row, input logic [15:0] col, input logic [3:0] rr);
    logic [15:0] exp_fc;
    logic [7:0]  exp_ec;
    bus.scan_row = row;
    bus.scan_col = col;
    bus.rd_row   = rr;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_edge(row, col, rr);
`ifdef LED_CAPTURE_STATS_EN
    exp_fc = m_frames;
    exp_ec = 8'(m_errs);
`else
    exp_fc = 16'd0;
    exp_ec = 8'd0;
`endif
    check("frame_done", {15'd0, bus.frame_done}, {15'd0, m_fd});
    check("err_seq",    {15'd0, bus.err_seq},    {15'd0, m_es});
    check("err_onehot", {15'd0, bus.err_onehot}, {15'd0, m_eo});
    check("locked",     {15'd0, bus.locked},     {15'd0, m_locked});
    check("rd_data",    bus.rd_data,             m_rd);
    check("frame_cnt",  bus.frame_cnt,           exp_fc);
    check("err_cnt",    {8'd0, bus.err_cnt},     {8'd0, exp_ec});
    if (bus.err_seq && bus.err_onehot) check("err_exclusive", 16'd1, 16'd0);
    fd_seen += int'(bus.frame_done);
    es_seen += int'(bus.err_seq);
    eo_seen += int'(bus.err_onehot);
  endtask

  task automatic clear_seen();
    fd_seen = 0; es_seen = 0; eo_seen = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle(bus.scan_row, bus.scan_col, bus.rd_row);
    rst = 1'b0;
  endtask

  task automatic scan_frame(input logic [15:0] base, input int dwell, input logic [3:0] rr);
    for (int k = 0; k < 16; k++)
      for (int d = 0; d < dwell; d++) cycle(16'h1 << k, base + 16'(k), rr);
  endtask

  initial begin
    logic [15:0] row, col;
    int k, r, dwell;

    bus.scan_row = '0; bus.scan_col = '0; bus.rd_row = '0;
    model_reset();
    do_reset(2);
    check("reset_locked", {15'd0, bus.locked}, 16'd0);
    check("reset_rd",     bus.rd_data, 16'd0);

    // Directed table: clean scan then skipped row
    for (int i = 0; i < 31; i++) begin
      if (i < 16)       begin tbl[i].row = 16'h1 << i;        tbl[i].col = 16'hA500 + 16'(i); end
      else if (i < 20)  begin tbl[i].row = 16'h8000;          tbl[i].col = 16'hA50F; end
      else if (i < 27)  begin tbl[i].row = 16'h1 << (i - 20); tbl[i].col = 16'h1100 + 16'(i); end
      else              begin tbl[i].row = 16'h0100;          tbl[i].col = 16'h1108; end
      tbl[i].rd_row = 4'd5;
      tbl[i].fd = (i == 16);
      tbl[i].lk = (i >= 1 && i < 28);
      tbl[i].es = (i == 28);
      tbl[i].eo = 1'b0;
      tbl[i].rd = (i >= 17) ? 16'hA505 : 16'h0000;
    end
    for (int i = 0; i < 31; i++) begin
      cycle(tbl[i].row, tbl[i].col, tbl[i].rd_row);
      check("tbl_fd", {15'd0, bus.frame_done}, {15'd0, tbl[i].fd});
      check("tbl_lk", {15'd0, bus.locked},     {15'd0, tbl[i].lk});
      check("tbl_es", {15'd0, bus.err_seq},    {15'd0, tbl[i].es});
      check("tbl_eo", {15'd0, bus.err_onehot}, {15'd0, tbl[i].eo});
      check("tbl_rd", bus.rd_data,             tbl[i].rd);
    end

    // Dwell of 3 cycles per row
    clear_seen();
    scan_frame(16'h5A00, 3, 4'd15);
    for (int i = 0; i < 3; i++) cycle(16'h8000, 16'h5A0F, 4'd15);
    check("dwell_fd_count", 16'(fd_seen), 16'd1);
    check("dwell_rd15", bus.rd_data, 16'h5A0F);
    check("dwell_locked", {15'd0, bus.locked}, 16'd1);

    // Two-hot row while locked, then re-lock
    clear_seen();
    cycle(16'h0001, 16'h0C00, 4'd3);
    cycle(16'h0002, 16'h0C01, 4'd3);
    for (int i = 0; i < 3; i++) cycle(16'h0003, 16'h0C02, 4'd3);
    check("twohot_eo_count", 16'(eo_seen), 16'd1);
    check("twohot_locked", {15'd0, bus.locked}, 16'd0);
    clear_seen();
    scan_frame(16'h3300, 1, 4'd3);
    for (int i = 0; i < 3; i++) cycle(16'h8000, 16'h330F, 4'd3);
    check("relock_fd_count", 16'(fd_seen), 16'd1);
    check("relock_rd3", bus.rd_data, 16'h3303);

    // Reset mid-frame
    for (int k2 = 0; k2 < 10; k2++) cycle(16'h1 << k2, 16'h7700 + 16'(k2), 4'd0);
    clear_seen();
    do_reset(1);
    check("rst_rd", bus.rd_data, 16'd0);
    check("rst_fd_count", 16'(fd_seen), 16'd0);
    for (int i = 0; i < 16; i++) begin
      cycle(16'h0200, 16'h7709, 4'(i));
      if (i > 0) check("rst_rd_row", bus.rd_data, 16'd0);
    end
    for (int k2 = 10; k2 < 16; k2++) cycle(16'h1 << k2, 16'h7700 + 16'(k2), 4'd0);
    cycle(16'h8000, 16'h770F, 4'd0);
    check("rst_partial_no_fd", 16'(fd_seen), 16'd0);
    scan_frame(16'h7700, 1, 4'd9);
    for (int i = 0; i < 3; i++) cycle(16'h8000, 16'h770F, 4'd9);
    check("rst_full_fd", 16'(fd_seen), 16'd1);
    check("rst_full_rd9", bus.rd_data, 16'h7709);

    // Statistics: 3 frames, then 300 sequence errors
    do_reset(1);
    for (int f = 0; f < 3; f++) scan_frame(16'h4000 + 16'(f << 8), 1, 4'd1);
    cycle(16'h8000, 16'h420F, 4'd1);
    cycle(16'h8000, 16'h420F, 4'd1);
`ifdef LED_CAPTURE_STATS_EN
    check("stats_frames", bus.frame_cnt, 16'd3);
`else
    check("stats_frames", bus.frame_cnt, 16'd0);
`endif
    clear_seen();
    for (int i = 0; i < 300; i++) begin
      cycle(16'h0001, 16'h0000, 4'd0);
      cycle(16'h0004, 16'h0000, 4'd0);
    end
    cycle(16'h0004, 16'h0000, 4'd0);
    cycle(16'h0004, 16'h0000, 4'd0);
    check("stats_es_count", 16'(es_seen), 16'd300);
`ifdef LED_CAPTURE_STATS_EN
    check("stats_errs", {8'd0, bus.err_cnt}, 16'd255);
`else
    check("stats_errs", {8'd0, bus.err_cnt}, 16'd0);
`endif

    // Randomized scans with occasional corruption and resets
    k = 0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      col = 16'($urandom);
      if (r < 80)      begin row = 16'h1 << k; k = (k + 1) % 16; end
      else if (r < 85) begin row = 16'h0001;   k = 1; end
      else if (r < 90) row = 16'h1 << $urandom_range(0, 15);
      else if (r < 94) row = 16'h0000;
      else             row = 16'($urandom);
      dwell = $urandom_range(1, 3);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        cycle(row, col, 4'($urandom_range(0, 15)));
        rst = 1'b0;
      end
      for (int d = 0; d < dwell; d++) cycle(row, col, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
